seq_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier. It computes an N-bit × N-bit product over N clock cycles and returns a 2N-bit result. It is the multiply counterpart to the sequential restoring divider in the floating-point arithmetic datapath, and it is sized by default for 24-bit single-precision mantissas. Operands are captured on a start handshake, and completion is flagged with a one-cycle done pulse.

---
 rtl/seq_multiplier.sv | 94 +++++++++
 tb/tb_seq_multiplier.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier: N x N -> 2N bits in N cycles.
// Operands are captured on an accepted start; a one-cycle done pulse marks completion.
module seq_multiplier #(
   parameter int unsigned N = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     multiplicand,
   input  logic [N-1:0]     multiplier,
   output logic             busy,
   output logic [2*N-1:0]   product,
   output logic             done
);

   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     hi_q, hi_d;
   logic [N-1:0]     lo_q, lo_d;
   logic [N-1:0]     a_q, a_d;
   logic [CW-1:0]    count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [2*N-1:0]   product_q, product_d;
   logic [N:0]       sum;

   // Extra top bit keeps the carry out of hi + a.
   assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      a_d       = a_q;
      count_d   = count_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      product_d = product_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = multiplicand;
               lo_d    = multiplier;
               hi_d    = '0;
               count_d = CW'(N);
               busy_d  = 1'b1;
               state_d = StBusy;
            end
         end
         StBusy: begin
            hi_d    = sum[N:1];
            lo_d    = {sum[0], lo_q[N-1:1]};
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               product_d = {sum[N:1], sum[0], lo_q[N-1:1]};
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         hi_q      <= '0;
         lo_q      <= '0;
         a_q       <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         a_q       <= a_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: the driver queues expected products and
// completion cycles; a negedge monitor checks done, busy and product every cycle.
module tb_seq_multiplier;

   localparam int unsigned N = 24;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [N-1:0]     a_in = '0;
   logic [N-1:0]     b_in = '0;
   logic             busy;
   logic             done;
   logic [2*N-1:0]   product;

   seq_multiplier #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (a_in),
      .multiplier   (b_in),
      .busy         (busy),
      .product      (product),
      .done         (done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2*N-1:0] prod;
      int unsigned    at;
   } exp_t;

   exp_t           sb[$];
   int unsigned    busy_from = 1;
   int unsigned    busy_to = 0;
   logic [2*N-1:0] exp_hold = '0;
   bit             mon_en = 1'b0;
   int             checks = 0;
   int             passes = 0;

   task automatic check(input string name, input logic [2*N-1:0] act,
                        input logic [2*N-1:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
   endtask

   // Monitor: decoupled from stimulus, only consumes the scoreboard.
   always @(negedge clk) begin
      logic exp_done;
      logic exp_busy;
      if (mon_en) begin
         exp_done = (sb.size() > 0) && (sb[0].at == cyc);
         exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
         check("done", {47'b0, done}, {47'b0, exp_done});
         check("busy", {47'b0, busy}, {47'b0, exp_busy});
         if (exp_done) begin
            exp_hold = sb[0].prod;
            void'(sb.pop_front());
         end
         check("product", product, exp_hold);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation. noise_at / abort_at name a BUSY cycle (1..N) at which a
   // stray start or a one-cycle reset is injected; 0 disables.
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                        input int noise_at, input int abort_at);
      int unsigned    e0;
      logic [2*N-1:0] p;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      e0    = cyc + 1;
      p     = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      sb.push_back('{prod: p, at: e0 + N});
      busy_from = e0;
      busy_to   = e0 + N - 1;
      step();
      for (int k = 1; k <= N; k++) begin
         if (k == noise_at) begin
            a_in  = N'($urandom);
            b_in  = N'($urandom);
            start = 1'b1;
         end else if (!hold) begin
            start = 1'b0;
         end
         if (k == abort_at) rst = 1'b1;
         step();
         if (k == abort_at) begin
            rst   = 1'b0;
            start = 1'b0;
            void'(sb.pop_back());
            exp_hold  = '0;
            busy_from = 1;
            busy_to   = 0;
            return;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      mon_en = 1'b1;
      rst    = 1'b0;
      step();

      issue(24'd1000, 24'd10, 1'b0, 0, 0);
      step();
      issue(24'd5000000, 24'd123, 1'b0, 0, 0);
      issue(24'd0, 24'd12345, 1'b0, 0, 0);
      step();
      issue(24'hFFFFFF, 24'hFFFFFF, 1'b0, 0, 0);
      issue(24'd1, 24'hFFFFFF, 1'b0, 0, 0);
      step();

      issue(24'd777, 24'd333, 1'b0, 5, 0);
      step();
      issue(24'd4321, 24'd1234, 1'b0, 0, 10);
      issue(24'd7, 24'd6, 1'b0, 0, 0);
      step();

      issue(24'd3, 24'd4, 1'b1, 0, 0);
      issue(24'd9, 24'd9, 1'b0, 0, 0);
      step();

      for (int i = 0; i < 20; i++) begin
         bit h;
         h = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
         issue(N'($urandom), N'($urandom), h, 0, 0);
         if (!h) repeat ($urandom_range(0, 3)) step();
      end

      repeat (3) step();
      check("scoreboard drained", 48'(sb.size()), 48'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
